// File: rtl/downcount_tc.sv
// Loadable down counter with one-cycle terminal-count pulse and Busy/Done status.
// Define DOWNCOUNT_AUTORELOAD_EN to make the terminal edge reload the last loaded value instead of stopping.
module downcount_tc #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Enable,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             TC,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
`ifdef DOWNCOUNT_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
`ifdef DOWNCOUNT_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (Load) begin
      // A zero load parks the counter in IDLE so no terminal pulse is ever produced for it.
      if (LoadVal != '0) begin
        count_d = LoadVal;
        state_d = RUN;
`ifdef DOWNCOUNT_AUTORELOAD_EN
        reload_d = LoadVal;
`endif
      end else begin
        count_d = '0;
        state_d = IDLE;
      end
    end else if (state_q == RUN && Enable) begin
      if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
`ifdef DOWNCOUNT_AUTORELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = DONE;
`endif
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tc_q     <= 1'b0;
`ifdef DOWNCOUNT_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
`ifdef DOWNCOUNT_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign Count = count_q;
  assign TC    = tc_q;
  assign Busy  = (state_q == RUN);
  assign Done  = (state_q == DONE);

endmodule

// File: tb/tb_downcount_tc.sv
// Scoreboard bench for downcount_tc: directed scenarios plus random load/enable traffic
// checked against a counting model; honours DOWNCOUNT_AUTORELOAD_EN.
module tb_downcount_tc;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         enable = 1'b0;
  logic [W-1:0] count;
  logic         busy, tc, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  // Model: how many enabled cycles remain, what to reload, and whether it is running / finished.
  int m_remaining = 0;
  int m_reload    = 0;
  bit m_running   = 0;
  bit m_finished  = 0;
  bit m_pulse     = 0;

  downcount_tc #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(rst), .Load(load), .LoadVal(load_val),
    .Enable(enable), .Count(count), .Busy(busy), .TC(tc), .Done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(bit ld, int val, bit en);
    m_pulse = 0;
    if (ld) begin
      m_remaining = val;
      m_finished  = 0;
      m_running   = (val != 0);
      if (val != 0) m_reload = val;
    end else if (m_running && en) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        m_pulse = 1;
`ifdef DOWNCOUNT_AUTORELOAD_EN
        m_remaining = m_reload;
`else
        m_running  = 0;
        m_finished = 1;
`endif
      end
    end
  endfunction

  function automatic void model_reset();
    m_remaining = 0;
    m_reload    = 0;
    m_running   = 0;
    m_finished  = 0;
    m_pulse     = 0;
  endfunction

  // One clock edge of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input bit ld, input int val, input bit en);
    exp_t e;
    load     = ld;
    load_val = W'(val);
    enable   = en;
    @(posedge clk);
    model_edge(ld, val, en);
    e.cnt  = W'(m_remaining);
    e.busy = m_running;
    e.tc   = m_pulse;
    e.done = m_finished;
    exp_q.push_back(e);
    #1;
  endtask

  // Asserted between edges: outputs must clear before any clock edge arrives.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (count !== '0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_%s: got count=%0d busy=%b tc=%b done=%b, want count=0 busy=0 tc=0 done=0",
               tag, count, busy, tc, done);
    end
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (count !== e.cnt || busy !== e.busy || tc !== e.tc || done !== e.done) begin
          miscompares++;
          $display("FAIL edge_check t=%0t: got count=%0d busy=%b tc=%b done=%b, want count=%0d busy=%b tc=%b done=%b",
                   $time, count, busy, tc, done, e.cnt, e.busy, e.tc, e.done);
        end else begin
          $display("ok   t=%0t count=%0d busy=%b tc=%b done=%b", $time, count, busy, tc, done);
        end
      end
    end
  end

  initial begin
    #1;
    do_reset("initial");

    // Load 5 with enable held: 5,4,3,2,1,0 and a single TC.
    step(1, 5, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // Load 3 with enable pattern 1,0,0,1,1.
    step(1, 3, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 1);

    // Terminal edge coinciding with a Load of 7: load wins.
    step(1, 2, 1);
    step(0, 0, 1);
    step(1, 7, 1);
    step(0, 0, 0);

    // Zero load: IDLE, enable ignored.
    step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Load 2 and enable for 8 cycles (one-shot or periodic depending on build).
    step(1, 2, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1);

    // Maximum load counts 2^W-1 enabled cycles.
    step(1, (1 << W) - 1, 1);
    for (int i = 0; i < (1 << W); i++) step(0, 0, 1);

    // Reset mid-count with Count=6.
    step(1, 8, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    do_reset("midcount");

    // Reset while a TC pulse is showing.
    step(1, 1, 0);
    step(0, 0, 1);
    do_reset("tc_pulse");

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("random");
      step($urandom_range(0, 9) == 0, int'($urandom_range(0, (1 << W) - 1)),
           $urandom_range(0, 9) < 7);
    end

    step(0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
